// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset high.
module uart_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, sampling on an oversample tick (clken).
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three ticks.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 clken,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitpos;
  logic [DATA_BITS-1:0] r_scratch;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rx_s;
  logic w_sample;
  logic w_cnt_inc;
  logic w_cnt_clr;
  logic w_shift;
  logic w_done_ok;
  logic w_done_err;

  uart_sync u_sync (
    .i_clk (clk_50m),
    .i_rst (rst),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The two previous ticks plus the current one form the three-tick vote window.
  logic [1:0] r_hist;

  always_ff @(posedge clk_50m) begin
    if (rst)        r_hist <= 2'b11;
    else if (clken) r_hist <= {r_hist[0], w_rx_s};
  end

  assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clk_50m) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clken && !w_rx_s) w_state_nxt = START;
      START:   if (clken && r_cnt == CNT_HALF) w_state_nxt = w_sample ? IDLE : DATA;
      DATA:    if (clken && r_cnt == CNT_LAST && r_bitpos == BIT_LAST) w_state_nxt = STOP;
      STOP:    if (clken && r_cnt == CNT_LAST) w_state_nxt = w_sample ? IDLE : BREAK;
      // A line held low after a bad stop bit must go high before a new start is accepted.
      BREAK:   if (w_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_inc  = 1'b0;
    w_shift    = 1'b0;
    w_done_ok  = 1'b0;
    w_done_err = 1'b0;
    w_cnt_clr  = (w_state_nxt != r_state);
    case (r_state)
      START: w_cnt_inc = clken;
      DATA: begin
        w_cnt_inc = clken;
        w_shift   = clken && (r_cnt == CNT_LAST);
      end
      STOP: begin
        w_cnt_inc  = clken;
        w_done_ok  = clken && (r_cnt == CNT_LAST) && w_sample;
        w_done_err = clken && (r_cnt == CNT_LAST) && !w_sample;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (w_shift) r_scratch[r_bitpos] <= w_sample;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bitpos    <= '0;
      r_data      <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);

      if (w_shift)              r_bitpos <= r_bitpos + BW'(1);
      else if (r_state != DATA) r_bitpos <= '0;

      if (w_done_ok) r_data <= r_scratch;

      // A completing byte takes priority over a simultaneous host acknowledge.
      r_rdy     <= w_done_ok | (r_rdy & ~rdy_clr);
      r_overrun <= (w_done_ok & r_rdy & ~rdy_clr) | (r_overrun & ~rdy_clr);

      if (w_done_ok)       r_frame_err <= 1'b0;
      else if (w_done_err) r_frame_err <= 1'b1;
    end
  end

  assign data      = r_data;
  assign rdy       = r_rdy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage, 8N1, LSB first; consumes the line driven by the existing UART transmitter.
- Samples an asynchronous rx pin on a 16x-baud enable tick (clken) from the shared baud generator, all logic on clk_50m.
- Presents each received byte with a sticky rdy flag, cleared by the host via rdy_clr.
- Reports framing errors and overruns.

Parameters:
- OVERSAMPLE, 16, clken ticks per bit period; power of two, ≥ 8.
- DATA_BITS, 8, bits per frame.

Ports:
- clk_50m  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- clken  in  1  single-cycle oversample tick at OVERSAMPLE × baud.
- rdy_clr  in  1  host acknowledge; clears rdy and overrun.
- data  out  8  last good received byte.
- rdy  out  1  new byte available (sticky).
- frame_err  out  1  last frame had stop bit = 0.
- overrun  out  1  a byte completed while rdy was still set.

Behaviour:
- Interface: one clock (clk_50m); reset is synchronous and active-high (rst).
- Reset values:
  - data = 0x00; rdy, frame_err, overrun = 0.
  - State = IDLE; counters = 0.
  - Synchronizer flops = 1.
- rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s. The synchronizer runs every clk_50m cycle.
- Sample counter cnt: log2(OVERSAMPLE) bits; advances only on clken. bitpos: 3 bits.
- States:
  - IDLE: on a clken with rx_s = 0, go to START, cnt = 0.
  - START: on clken, cnt increments. When cnt reaches OVERSAMPLE/2 − 1 (mid start bit):
    - rx_s = 0: go to DATA, cnt = 0, bitpos = 0.
    - rx_s = 1: glitch; return to IDLE with no flag change.
  - DATA: on clken, cnt increments. At cnt = OVERSAMPLE − 1 (mid bit):
    - shift the sampled bit into scratch[bitpos]; bitpos increments.
    - after bit 7, go to STOP, cnt = 0.
  - STOP: at cnt = OVERSAMPLE − 1, sample the stop bit.
    - Stop = 1: data ← scratch, rdy ← 1, frame_err ← 0; go to IDLE.
    - Stop = 0: frame_err ← 1, data and rdy unchanged; go to BREAK.
  - BREAK: wait for rx_s = 1 (any cycle), then go to IDLE. This prevents a held-low line from retriggering.
  - Any illegal state encoding goes to IDLE.
- Latency: rdy and data update on the clk_50m edge that processes the stop-bit clken tick.
- rdy: set on good completion; cleared on rdy_clr. Set and clear in the same cycle: set wins.
- overrun: set when a good byte completes while rdy = 1 and rdy_clr = 0 that cycle. The new byte overwrites data. Cleared by rdy_clr; if set and clear coincide, set wins.
- frame_err: updated per frame only; not cleared by rdy_clr.
- clken = 0 freezes cnt and state progression (except the BREAK exit and the synchronizer).
- rst mid-frame: return to IDLE immediately and apply all reset values. The partial byte is discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - A 3-bit history of rx_s is shifted on every clken.
  - Each bit/start/stop sample uses the 2-of-3 majority of the last three ticks.
  - This rejects single-tick glitches.
- Undefined:
  - The sample is rx_s at the sample tick; no history register is instantiated.

Decomposition:
- Package uart_pkg:
  - rx state enum: IDLE, START, DATA, STOP, BREAK (3-bit).
  - DATA_BITS and default OVERSAMPLE constants.
  - Transmitter state constants relocated here later.
- Sub-module uart_sync: 2-flop synchronizer, reset value 1. Also reusable for other async inputs.

Test Plan (clken every 4 clk_50m cycles, frame bits 16 ticks each, rdy_clr not pulsed unless stated):
1. Send 0x55 with a valid stop bit → rdy = 1, data = 0x55, frame_err = 0, overrun = 0.
2. rx low for 4 ticks then high, then send 0xA3 → no rdy from the glitch; afterwards data = 0xA3, rdy = 1.
3. Send 0x0F with stop = 0, hold rx low 3 bit times, release, send 0x81 →
   - first frame: frame_err = 1, rdy = 0, data = 0x00.
   - no frame decoded during the hold.
   - then data = 0x81, frame_err = 0.
4. Send 0x12 then 0x34 without rdy_clr → data = 0x34, rdy = 1, overrun = 1. Then pulse rdy_clr → rdy = 0, overrun = 0.
5. With rdy = 1, pulse rdy_clr on the exact cycle 0x77 completes → rdy = 1, overrun = 0, data = 0x77.
6. Assert rst during bit 4 of 0xC6 → all outputs 0 on the next edge. Next frame 0x3C → data = 0x3C.
   - With UART_RX_MAJORITY_EN: a 1-tick low glitch at the mid-sample of bit 3 of 0xFF → data = 0xFF.
